// File: rtl/mem_access_unit.sv
// mem_access_unit
//
// Converts byte/half/word load and store requests at any byte alignment into
// word-aligned memory accesses. An access that crosses a word boundary is
// split into two consecutive word accesses (ACC0 then ACC1). Load data is
// reassembled, shifted down and sign- or zero-extended before it is returned.
//
// Ports
//   clk, rst_n        single rising-edge clock, asynchronous active-low reset
//   req_*             request channel (valid/ready); size 3 is illegal
//   resp_*            response channel (valid/ready); rdata is 0 for stores
//   mem_addr          word-aligned memory address
//   mem_wr_en         write strobe, only asserted during ACC0/ACC1 of a store
//   mem_byte_en       per-lane enables, bit i = byte lane i
//   mem_wr_data       lane-positioned store data
//   mem_rd_data       read word, valid one cycle after mem_addr is presented
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [3:0]        mem_byte_en,
  output logic [31:0]       mem_wr_data,
  input  logic [31:0]       mem_rd_data
);

  typedef enum logic [2:0] {
    IDLE,
    ACC0,
    ACC1,
    CAP,
    RESP
  } state_t;

  state_t            state;
  logic              store_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word0_q;

  logic [3:0]        lo_byte_en;
  logic [31:0]       lo_wr_data;
  logic [3:0]        hi_byte_en;
  logic [31:0]       hi_wr_data;
  logic              split;
  logic [31:0]       cap_result;

  function automatic logic [3:0] num_bytes(input logic [1:0] size);
    case (size)
      2'd0:    return 4'd1;
      2'd1:    return 4'd2;
      default: return 4'd4;
    endcase
  endfunction

  // 8-bit lane mask spanning both words of a potentially split access.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

  function automatic logic is_split(input logic [1:0] size, input logic [1:0] off);
    return ({2'b00, off} + num_bytes(size)) > 4'd4;
  endfunction

  function automatic logic [63:0] write_image(input logic [31:0] wdata, input logic [1:0] off);
    return {32'h0, wdata} << {off, 3'b000};
  endfunction

  // {word1, word0} shifted down by the byte offset, then truncated and extended.
  function automatic logic [31:0] load_result(input logic [31:0] w1, input logic [31:0] w0,
                                              input logic [1:0] off, input logic [1:0] size,
                                              input logic sgn);
    logic [31:0] sh;
    sh = 32'({w1, w0} >> {off, 3'b000});
    case (size)
      2'd0:    return {{24{sgn & sh[7]}}, sh[7:0]};
      2'd1:    return {{16{sgn & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  // The first access is launched on the accept edge, so its lane enables and
  // data come straight from the request inputs; the second access uses the
  // latched request.
  always_comb begin
    lo_byte_en = 4'(lane_mask(req_size, req_addr[1:0]));
    lo_wr_data = req_wdata << {req_addr[1:0], 3'b000};
    hi_byte_en = 4'(lane_mask(size_q, addr_q[1:0]) >> 4);
    hi_wr_data = 32'(write_image(wdata_q, addr_q[1:0]) >> 32);
    split      = is_split(size_q, addr_q[1:0]);
    // In CAP the read word belongs to the second access of a split load,
    // or is the only word of an unsplit one (upper word then counts as 0).
    if (split)
      cap_result = load_result(mem_rd_data, word0_q, addr_q[1:0], size_q, signed_q);
    else
      cap_result = load_result(32'h0, mem_rd_data, addr_q[1:0], size_q, signed_q);
  end

  // Control FSM; every output is a register updated on the state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'h0;
      resp_err    <= 1'b0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_byte_en <= 4'h0;
      mem_wr_data <= 32'h0;
      store_q     <= 1'b0;
      size_q      <= 2'd0;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      word0_q     <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            store_q   <= req_store;
            size_q    <= req_size;
            signed_q  <= req_signed;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_size == 2'd3) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              state       <= ACC0;
              mem_addr    <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wr_en   <= req_store;
              mem_byte_en <= lo_byte_en;
              mem_wr_data <= lo_wr_data;
            end
          end
        end

        ACC0: begin
          if (split) begin
            state       <= ACC1;
            mem_addr    <= mem_addr + ADDR_W'(4);
            mem_wr_en   <= store_q;
            mem_byte_en <= hi_byte_en;
            mem_wr_data <= hi_wr_data;
          end else begin
            mem_wr_en   <= 1'b0;
            mem_byte_en <= 4'h0;
            if (store_q) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= 32'h0;
            end else begin
              state <= CAP;
            end
          end
        end

        ACC1: begin
          mem_wr_en   <= 1'b0;
          mem_byte_en <= 4'h0;
          if (store_q) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
          end else begin
            word0_q <= mem_rd_data;
            state   <= CAP;
          end
        end

        CAP: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= cap_result;
        end

        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            req_ready  <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          req_ready   <= 1'b1;
          resp_valid  <= 1'b0;
          mem_wr_en   <= 1'b0;
          mem_byte_en <= 4'h0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1, access request present.
REQ-005 SHALL have port req_ready, output, 1, unit can accept a request.
REQ-006 SHALL have port req_store, input, 1, 1=store, 0=load.
REQ-007 SHALL have port req_size, input, 2, 0=byte, 1=half, 2=word, 3=illegal.
REQ-008 SHALL have port req_signed, input, 1, sign-extend load result.
REQ-009 SHALL have port req_addr, input, ADDR_W, byte address, any alignment.
REQ-010 SHALL have port req_wdata, input, 32, store data, right-justified.
REQ-011 SHALL have port resp_valid, output, 1, response present.
REQ-012 SHALL have port resp_ready, input, 1, consumer accepts response.
REQ-013 SHALL have port resp_rdata, output, 32, extended load data; 0 for stores.
REQ-014 SHALL have port resp_err, output, 1, illegal size flagged.
REQ-015 SHALL have port mem_addr, output, ADDR_W, word-aligned address (bits [1:0]=0).
REQ-016 SHALL have port mem_wr_en, output, 1, write strobe.
REQ-017 SHALL have port mem_byte_en, output, 4, lane enables, bit i = byte lane i.
REQ-018 SHALL have port mem_wr_data, output, 32, lane-positioned write data.
REQ-019 SHALL have port mem_rd_data, input, 32, memory read word, valid one cycle after mem_addr is driven with mem_wr_en=0.

Function
REQ-020 SHALL implement FSM states IDLE, ACC0, ACC1, CAP, RESP; req_ready=1 only in IDLE.
REQ-021 SHALL latch store, size, signed, addr, wdata on accept (req_valid && req_ready) and go to ACC0; size 3 goes directly to RESP with resp_err=1, resp_rdata=0, no memory access.
REQ-022 SHALL compute off=addr[1:0], nbytes=1/2/4, 8-bit lane mask = ((1<<nbytes)-1)<<off; split = off+nbytes>4.
REQ-023 SHALL in ACC0 drive mem_addr={addr[ADDR_W-1:2],2'b00}, mem_byte_en=mask[3:0]; in ACC1 drive mem_addr=ACC0 address+4 (wraps modulo 2^ADDR_W), mem_byte_en=mask[7:4].
REQ-024 SHALL form 64-bit write image = zero-extended wdata << (8*off); ACC0 drives bits [31:0], ACC1 bits [63:32]; mem_wr_en=store in ACC0/ACC1 only.
REQ-025 SHALL drive mem_wr_en=0, mem_byte_en=0 in IDLE, CAP, RESP; mem_addr/mem_wr_data don't-care there.
REQ-026 Store transitions: ACC0 -> ACC1 if split else RESP; ACC1 -> RESP.
REQ-027 Load transitions: ACC0 -> ACC1 if split else CAP; ACC1 captures mem_rd_data as word0 and -> CAP; CAP captures mem_rd_data as word1 if split else word0, -> RESP.
REQ-028 SHALL compute load result = ({word1,word0} >> 8*off) truncated to nbytes, sign-extended if signed else zero-extended; unused word1 treated as 0.
REQ-029 SHALL hold resp_valid=1 and resp_rdata/resp_err stable in RESP until resp_ready; on resp_ready -> IDLE; no new request accepted in the same cycle.
REQ-030 Latency (accept at cycle T): unsplit load resp_valid at T+3, split load T+4, unsplit store T+2, split store T+3, illegal T+1.

Reset
REQ-031 SHALL on rst_n=0 immediately enter IDLE, force resp_valid=0, resp_err=0, resp_rdata=0, mem_wr_en=0, mem_byte_en=0, mem_addr=0, mem_wr_data=0, req_ready=1 after release.
REQ-032 SHALL abandon any in-flight access on reset, including between the two halves of a split store (first half may be committed; second SHALL NOT be issued).

Verification
REQ-033 Word store 0xF0F0F0F0 @0x0, then signed word load @0x0 -> one write, byte_en=1111, addr 0x0; load resp_rdata=0xF0F0F0F0 at T+3.
REQ-034 Half store 0xAAAA @0x1 -> single write addr 0x0 byte_en=0110 wr_data=0x00AAAA00; unsigned half load @0x1 -> 0x0000AAAA.
REQ-035 Half store 0xBEEF @0x3 -> writes addr 0x0 byte_en=1000 data 0xEF000000, then addr 0x4 byte_en=0001 data 0x000000BE; signed half load @0x3 -> 0xFFFFBEEF at T+4.
REQ-036 Byte 0xCC @0x5: signed load -> 0xFFFFFFCC, unsigned -> 0x000000CC; word store @0xFFFFFFFE wraps second access to addr 0x0 byte_en=0011.
REQ-037 req_size=3 -> resp_err=1 at T+1, no mem_wr_en; resp_ready held low 3 cycles -> resp_valid and data held stable, req_ready=0.
REQ-038 rst_n asserted during ACC1 of split store -> outputs zero asynchronously, second write never issued, req_ready=1 after release.
